mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameters SHALL be: n, 16, data-bus width; BASE_ADDR, 16'hFF00, address of TXDATA register; CLKS_PER_BIT, 16, clk cycles per serial bit (>=2); FIFO_DEPTH, 4, transmit FIFO entries (power of 2).
REQ-002 Ports SHALL be one per line as follows; one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 memwrite  input  1  CPU data-bus store strobe.
REQ-006 dataadr  input  n  CPU data-bus byte address.
REQ-007 writedata  input  n  CPU store data.
REQ-008 readdata  output  n  load data; 0 when dataadr is not a block register.
REQ-009 tx  output  1  serial line, idle high, registered.

Function
REQ-010 Block SHALL be a data-bus responder decoding two registers: TXDATA at BASE_ADDR, STATUS at BASE_ADDR+2; all other addresses ignored.
REQ-011 memwrite=1 with dataadr=TXDATA SHALL push writedata[7:0] into FIFO at that edge if FIFO not full.
REQ-012 Push to full FIFO SHALL drop the byte and set sticky overflow flag.
REQ-013 memwrite=1 with dataadr=STATUS and writedata[3]=1 SHALL clear overflow; other STATUS bits read-only.
REQ-014 readdata SHALL be combinational: at STATUS -> {zeros, count[ceil(log2(FIFO_DEPTH+1))-1:0] at bits [n-1:4], overflow bit3, empty bit2, full bit1, busy bit0}; at TXDATA -> 0.
REQ-015 busy SHALL be 1 whenever FSM is not IDLE.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE with FIFO non-empty at an edge SHALL pop head, load shifter, enter START, drive tx=0 from that edge.
REQ-018 Each state SHALL hold for exactly CLKS_PER_BIT cycles via a bit timer counting 0..CLKS_PER_BIT-1.
REQ-019 DATA SHALL send 8 bits LSB first, bit index 0..7, then enter STOP with tx=1.
REQ-020 End of STOP SHALL enter START directly (no idle gap) if FIFO non-empty, else IDLE.
REQ-021 Latency: byte written at edge E0 into empty FIFO with FSM IDLE SHALL drive tx low after edge E0+1.
REQ-022 Simultaneous push and pop SHALL both succeed, including when FIFO full; count unchanged.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-024 Writes to TXDATA during a frame SHALL NOT disturb the frame in progress.

Reset
REQ-025 reset=1 at an edge SHALL set tx=1, state IDLE, FIFO empty (count 0, pointers 0), overflow 0, bit timer and bit index 0.
REQ-026 reset mid-frame SHALL abort the frame; tx=1 after that edge; queued bytes discarded.
REQ-027 reset SHALL take priority over a simultaneous push.

Configuration
REQ-028 Macro MMIO_UART_TX_PARITY_EN defined SHALL add state PARITY between DATA and STOP sending even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles; 11-bit frame.
REQ-029 MMIO_UART_TX_PARITY_EN undefined SHALL give 8N1 10-bit frame with no PARITY state.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Reset then idle -> tx=1, STATUS reads 16'h0004.
REQ-031 Store 8'hA5 to FF00 -> tx low one edge later; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high; frame 40 cycles (44 with parity, parity bit 0); busy 1 throughout.
REQ-032 Store 6 bytes back-to-back while IDLE -> first popped at once, next 4 queued, sixth dropped; STATUS overflow=1, full=1; 5 frames sent contiguous, no gap.
REQ-033 Store to STATUS with writedata=16'h0008 -> overflow cleared, other fields unchanged.
REQ-034 Assert reset for one cycle during DATA bit 3 with 2 bytes queued -> tx=1 next edge, STATUS=16'h0004, no further frames.
REQ-035 Load from FF04 and store to FF04 -> readdata=0, no FIFO or state change.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, small TX FIFO and a 8N1 serializer.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1 frame).
module mmio_uart_tx #(
    parameter int unsigned  n            = 16,
    parameter logic [n-1:0] BASE_ADDR    = 16'hFF00,
    parameter int unsigned  CLKS_PER_BIT = 16,
    parameter int unsigned  FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memwrite,
    input  logic [n-1:0] dataadr,
    input  logic [n-1:0] writedata,
    output logic [n-1:0] readdata,
    output logic         tx
);

    localparam int unsigned  PW          = $clog2(FIFO_DEPTH);
    localparam int unsigned  CW          = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned  TW          = $clog2(CLKS_PER_BIT);
    localparam logic [n-1:0] STATUS_ADDR = BASE_ADDR + n'(2);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

`ifdef MMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
`endif

    state_t          state_r, state_s;
    logic [TW-1:0]   timer_r, timer_s;
    logic [2:0]      bitidx_r, bitidx_s;
    logic [7:0]      shift_r, shift_s;
    logic            tx_r, tx_s;

    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wptr_r, rptr_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;

    logic            push_req_s, push_s, pop_s, clr_ovf_s;
    logic            full_s, empty_s, busy_s, timer_end_s;
    logic            unused_s;

    assign full_s      = (count_r == DEPTH_C);
    assign empty_s     = (count_r == CW'(0));
    assign busy_s      = (state_r != IDLE);
    assign timer_end_s = (timer_r == TIMER_LAST);
    assign push_req_s  = memwrite && (dataadr == BASE_ADDR);
    assign clr_ovf_s   = memwrite && (dataadr == STATUS_ADDR) && writedata[3];
    // A full FIFO still accepts a byte when the serializer pops in the same cycle.
    assign push_s      = push_req_s && (!full_s || pop_s);
    assign unused_s    = ^writedata[n-1:8];
    assign tx          = tx_r;

    // Frame sequencer: next state, bit timer, bit index, shifter load and FIFO pop.
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_end_s ? TW'(0) : timer_r + TW'(1);
        bitidx_s = bitidx_r;
        shift_s  = shift_r;
        pop_s    = 1'b0;
        case (state_r)
            IDLE: begin
                timer_s  = TW'(0);
                bitidx_s = 3'd0;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = mem_r[rptr_r];
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (timer_end_s) begin
                    bitidx_s = 3'd0;
                    state_s  = DATA;
                end else begin
                    state_s  = START;
                end
            end
            DATA: begin
                if (timer_end_s && (bitidx_r == 3'd7)) begin
`ifdef MMIO_UART_TX_PARITY_EN
                    state_s  = PARITY;
`else
                    state_s  = STOP;
`endif
                end else if (timer_end_s) begin
                    bitidx_s = bitidx_r + 3'd1;
                end else begin
                    state_s  = DATA;
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: begin
                if (timer_end_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (timer_end_s && !empty_s) begin
                    pop_s    = 1'b1;
                    shift_s  = mem_r[rptr_r];
                    bitidx_s = 3'd0;
                    state_s  = START;
                end else if (timer_end_s) begin
                    state_s  = IDLE;
                end else begin
                    state_s  = STOP;
                end
            end
            default: begin
                state_s  = IDLE;
                timer_s  = TW'(0);
                bitidx_s = 3'd0;
            end
        endcase
    end

    // Line level for the state being entered, so tx is registered with its state.
    always_comb begin
        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[bitidx_s];
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY:  tx_s = ^shift_s;
`endif
            default: tx_s = 1'b1;
        endcase
    end

    // Serializer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            timer_r  <= TW'(0);
            bitidx_r <= 3'd0;
            shift_r  <= 8'h00;
            tx_r     <= 1'b1;
        end else begin
            state_r  <= state_s;
            timer_r  <= timer_s;
            bitidx_r <= bitidx_s;
            shift_r  <= shift_s;
            tx_r     <= tx_s;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r     <= PW'(0);
            rptr_r     <= PW'(0);
            count_r    <= CW'(0);
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push_req_s && !push_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_r[wptr_r] <= writedata[7:0];
        end
    end

    // Load path: only STATUS returns data.
    always_comb begin
        readdata = n'(0);
        if (dataadr == STATUS_ADDR) begin
            readdata[3:0]     = {overflow_r, empty_s, full_s, busy_s};
            readdata[4 +: CW] = count_r;
        end else begin
            readdata = n'(0);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected bytes, a tx-line monitor
// decodes frames and compares them; STATUS and latency are checked directly.
module tb_mmio_uart_tx;

    localparam int CPB = 4;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int STOP_OFF = 10 * CPB;
`else
    localparam int STOP_OFF = 9 * CPB;
`endif
    localparam int FRAME = STOP_OFF + CPB;
    localparam logic [15:0] BASE = 16'hFF00;
    localparam logic [15:0] STAT = 16'hFF02;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [15:0] dataadr = 16'h0000;
    logic [15:0] writedata = 16'h0000;
    logic [15:0] readdata;
    logic        tx;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] sb_q[$];
    int         frame_starts[$];

    int         mon_cyc = -1;
    logic       mon_abort = 1'b0;
    logic       prev_tx = 1'b1;
    logic [7:0] mon_byte = 8'h00;

    mmio_uart_tx #(
        .n(16), .BASE_ADDR(16'hFF00), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .readdata(readdata), .tx(tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) mon_abort = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
    endtask

    // Frame monitor: decodes the serial line and checks against the scoreboard queue.
    always @(negedge clk) begin
        if (mon_abort) begin
            mon_cyc   = -1;
            mon_abort = 1'b0;
        end else if (mon_cyc < 0) begin
            if (prev_tx === 1'b1 && tx === 1'b0) begin
                mon_cyc = 0;
                frame_starts.push_back(cyc);
            end
        end else begin
            mon_cyc = mon_cyc + 1;
            if (mon_cyc == 2) begin
                chk("start_bit", {31'd0, tx}, 32'd0);
            end else if (mon_cyc >= CPB + 1 && mon_cyc < 9 * CPB && (mon_cyc - 1) % CPB == 0) begin
                mon_byte[(mon_cyc - 1) / CPB - 1] = tx;
`ifdef MMIO_UART_TX_PARITY_EN
            end else if (mon_cyc == 9 * CPB + 1) begin
                if (sb_q.size() != 0) chk("parity_bit", {31'd0, tx}, {31'd0, ^sb_q[0]});
`endif
            end else if (mon_cyc == STOP_OFF + 1) begin
                chk("stop_bit", {31'd0, tx}, 32'd1);
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got byte %0h, no byte expected", mon_byte);
                end else begin
                    chk("frame_byte", {24'd0, mon_byte}, {24'd0, sb_q.pop_front()});
                end
            end
            if (mon_cyc == FRAME - 1) mon_cyc = -1;
        end
        prev_tx = tx;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int k;
        logic busy_ok;

        // Reset and idle
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        dataadr = STAT;
        #1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_status", {16'd0, readdata}, 32'h0004);

        // Single byte A5: latency, busy through the frame, idle afterwards
        wr(BASE, 16'h00A5);
        sb_q.push_back(8'hA5);
        @(negedge clk);
        memwrite = 1'b0;
        dataadr  = STAT;
        #1;
        chk("lat_tx_still_high", {31'd0, tx}, 32'd1);
        chk("lat_status_queued", {16'd0, readdata}, 32'h0010);
        @(negedge clk);
        #1;
        chk("lat_tx_low", {31'd0, tx}, 32'd0);
        chk("start_status", {16'd0, readdata}, 32'h0005);
        busy_ok = 1'b1;
        for (int i = 1; i < FRAME; i++) begin
            @(negedge clk);
            #1;
            if (readdata[0] !== 1'b1) busy_ok = 1'b0;
        end
        chk("busy_frame", {31'd0, busy_ok}, 32'd1);
        @(negedge clk);
        #1;
        chk("idle_after_frame", {16'd0, readdata}, 32'h0004);
        chk("idle_tx", {31'd0, tx}, 32'd1);
        chk("a5_done", sb_q.size(), 32'd0);

        // Six back-to-back stores: one popped, four queued, one dropped
        frame_starts.delete();
        wr(BASE, 16'h0011);
        wr(BASE, 16'h0022);
        wr(BASE, 16'h0033);
        wr(BASE, 16'h0044);
        wr(BASE, 16'h0055);
        wr(BASE, 16'h0066);
        sb_q.push_back(8'h11);
        sb_q.push_back(8'h22);
        sb_q.push_back(8'h33);
        sb_q.push_back(8'h44);
        sb_q.push_back(8'h55);
        @(negedge clk);
        memwrite = 1'b0;
        dataadr  = STAT;
        #1;
        chk("burst_status", {16'd0, readdata}, 32'h004B);
        wr(STAT, 16'h0008);
        @(negedge clk);
        memwrite = 1'b0;
        dataadr  = STAT;
        #1;
        chk("ovf_clear_status", {16'd0, readdata}, 32'h0043);
        chk("burst_started", frame_starts.size(), 32'd1);
        s0 = (frame_starts.size() > 0) ? frame_starts[0] : cyc;

        // Push into the full FIFO on the very edge the next byte is popped
        while (cyc < s0 + FRAME - 1) @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = BASE;
        writedata = 16'h0077;
        sb_q.push_back(8'h77);
        @(negedge clk);
        memwrite = 1'b0;
        dataadr  = STAT;
        #1;
        chk("push_pop_full", {16'd0, readdata}, 32'h0043);

        k = 0;
        while (sb_q.size() != 0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("burst_drained", sb_q.size(), 32'd0);
        repeat (CPB) @(negedge clk);
        #1;
        chk("burst_frames", frame_starts.size(), 32'd6);
        for (int i = 1; i < frame_starts.size(); i++) begin
            chk("frame_gap", frame_starts[i] - frame_starts[i-1], FRAME);
        end
        chk("burst_end_status", {16'd0, readdata}, 32'h0004);

        // Unmapped address FF04: ignored on load and store
        frame_starts.delete();
        wr(16'hFF04, 16'hFFFF);
        @(negedge clk);
        memwrite = 1'b0;
        #1;
        chk("unmapped_read", {16'd0, readdata}, 32'h0000);
        dataadr = BASE;
        #1;
        chk("txdata_read", {16'd0, readdata}, 32'h0000);
        dataadr = STAT;
        #1;
        chk("unmapped_status", {16'd0, readdata}, 32'h0004);
        repeat (10) @(negedge clk);
        chk("unmapped_no_frame", frame_starts.size(), 32'd0);

        // Reset during data bit 3 with two bytes queued, colliding with a push
        wr(BASE, 16'h003C);
        wr(BASE, 16'h00C3);
        wr(BASE, 16'h005A);
        @(negedge clk);
        memwrite = 1'b0;
        dataadr  = STAT;
        k = 0;
        while (frame_starts.size() == 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("abort_frame_started", frame_starts.size(), 32'd1);
        s0 = (frame_starts.size() > 0) ? frame_starts[0] : cyc;
        while (cyc < s0 + 16) @(negedge clk);
        #1;
        chk("pre_reset_status", {16'd0, readdata}, 32'h0021);
        @(negedge clk);
        reset     = 1'b1;
        memwrite  = 1'b1;
        dataadr   = BASE;
        writedata = 16'h0077;
        @(negedge clk);
        reset    = 1'b0;
        memwrite = 1'b0;
        dataadr  = STAT;
        #1;
        chk("reset_abort_tx", {31'd0, tx}, 32'd1);
        chk("reset_abort_status", {16'd0, readdata}, 32'h0004);
        frame_starts.delete();
        repeat (100) @(negedge clk);
        #1;
        chk("reset_no_frames", frame_starts.size(), 32'd0);
        chk("reset_idle_tx", {31'd0, tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
